sdram_responder: RTL

- Synthesizable target-side model of the single-data-rate x8 SDRAM command interface; it is the device end of the bus our SDRAM controller drives.
- Decodes CKE/CS/RAS/CAS/WE commands and tracks per-bank open rows, the init sequence and the mode register.
- Backs accesses with a small on-chip byte array and returns read data at the programmed CAS latency.
- Flags protocol and timing violations so controller benches and on-FPGA loopback tests can self-check.

---
 rtl/sdram_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// Device-side model of an SDR x8 SDRAM: command decode, init/mode tracking,
// per-bank row state with tRCD/tRP checks, small backing array and CL read pipe.
module sdram_responder #(
  parameter int ROW_WIDTH     = 13,
  parameter int COL_WIDTH     = 10,
  parameter int BANK_WIDTH    = 2,
  parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  parameter int STORE_WIDTH   = 10,
  parameter int T_RCD         = 2,
  parameter int T_RP          = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clock_enable,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [SDRADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0]    bank_addr,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     data_oe,
  input  logic                     data_mask,
  output logic                     init_done,
  output logic                     error,
  output logic [2:0]               error_code,
  output logic [2:0]               cas_latency
);

  localparam int NBANK = 1 << BANK_WIDTH;
  localparam int TW    = 4;
  localparam logic [TW-1:0] TRCD_C = TW'(T_RCD);
  localparam logic [TW-1:0] TRP_C  = TW'(T_RP);

  typedef enum logic [2:0] {S_UNINIT, S_PRECHG, S_REF1, S_READY_MRS, S_READY} init_t;
  typedef enum logic [2:0] {C_NOP, C_PRE, C_REF, C_MRS, C_ACT, C_READ, C_WRITE} cmd_t;

  init_t                  r_state, w_state_nx;
  cmd_t                   w_cmd;
  logic [NBANK-1:0]       r_open;
  logic [ROW_WIDTH-1:0]   r_row     [NBANK];
  logic [TW-1:0]          r_act_tmr [NBANK];
  logic [TW-1:0]          r_pre_tmr [NBANK];
  logic [2:0]             r_cl;
  logic                   r_error;
  logic [2:0]             r_code;
  logic [1:0]             r_pv;
  logic [7:0]             r_pd      [2];
  logic [7:0]             r_data_out;
  logic                   r_data_oe;
  logic [7:0]             r_mem     [1 << STORE_WIDTH];

  logic                   w_err, w_do_act, w_do_rd, w_do_wr, w_do_mrs, w_mrs_ok;
  logic [2:0]             w_code;
  logic [NBANK-1:0]       w_pre_mask;
  logic [STORE_WIDTH-1:0] w_idx;
  logic [7:0]             w_rd_byte;

  always_comb begin
    w_cmd = C_NOP;
    if (clock_enable && !cs_n) begin
      unique case ({ras_n, cas_n, we_n})
        3'b010:  w_cmd = C_PRE;
        3'b001:  w_cmd = C_REF;
        3'b000:  w_cmd = C_MRS;
        3'b011:  w_cmd = C_ACT;
        3'b101:  w_cmd = C_READ;
        3'b100:  w_cmd = C_WRITE;
        default: w_cmd = C_NOP;
      endcase
    end
  end

  assign w_mrs_ok  = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
  assign w_idx     = STORE_WIDTH'({bank_addr, r_row[bank_addr], addr[COL_WIDTH-1:0]});
  assign w_rd_byte = r_mem[w_idx];

  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    w_code     = 3'd0;
    w_do_act   = 1'b0;
    w_do_rd    = 1'b0;
    w_do_wr    = 1'b0;
    w_do_mrs   = 1'b0;
    w_pre_mask = '0;
    case (w_cmd)
      C_PRE: begin
        if (addr[10]) w_pre_mask = '1;
        else          w_pre_mask[bank_addr] = 1'b1;
        if (addr[10] && r_state == S_UNINIT) w_state_nx = S_PRECHG;
      end
      C_REF: begin
        if (|r_open) begin
          w_err = 1'b1; w_code = 3'd6;
        end else if (r_state == S_PRECHG) begin
          w_state_nx = S_REF1;
        end else if (r_state == S_REF1) begin
          w_state_nx = S_READY_MRS;
        end
      end
      C_MRS: begin
        if (r_state != S_READY_MRS && r_state != S_READY) begin
          w_err = 1'b1; w_code = 3'd4;
        end else if (|r_open) begin
          w_err = 1'b1; w_code = 3'd6;
        end else if (!w_mrs_ok) begin
          w_err = 1'b1; w_code = 3'd5;
        end else begin
          w_do_mrs   = 1'b1;
          w_state_nx = S_READY;
        end
      end
      C_ACT: begin
        if (r_state != S_READY) begin
          w_err = 1'b1; w_code = 3'd4;
        end else if (r_open[bank_addr]) begin
          w_err = 1'b1; w_code = 3'd1;
        end else if (r_pre_tmr[bank_addr] < TRP_C) begin
          w_err = 1'b1; w_code = 3'd7;
        end else begin
          w_do_act = 1'b1;
        end
      end
      C_READ, C_WRITE: begin
        if (r_state != S_READY) begin
          w_err = 1'b1; w_code = 3'd4;
        end else if (!r_open[bank_addr]) begin
          w_err = 1'b1; w_code = 3'd2;
        end else if (r_act_tmr[bank_addr] < TRCD_C) begin
          w_err = 1'b1; w_code = 3'd3;
        end else if (w_cmd == C_READ) begin
          w_do_rd = 1'b1;
        end else begin
          w_do_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Timers hold the edge count since their event: setting 1 here means the next edge reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_UNINIT;
      r_open     <= '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
        r_act_tmr[BANK_WIDTH'(b)] <= '1;
        r_pre_tmr[BANK_WIDTH'(b)] <= '1;
        r_row[BANK_WIDTH'(b)]     <= '0;
      end
      r_cl       <= 3'd2;
      r_error    <= 1'b0;
      r_code     <= 3'd0;
      r_pv       <= '0;
      r_pd[0]    <= '0;
      r_pd[1]    <= '0;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_err && !r_error) begin
        r_error <= 1'b1;
        r_code  <= w_code;
      end
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (r_act_tmr[BANK_WIDTH'(b)] != '1) r_act_tmr[BANK_WIDTH'(b)] <= r_act_tmr[BANK_WIDTH'(b)] + 1'b1;
        if (r_pre_tmr[BANK_WIDTH'(b)] != '1) r_pre_tmr[BANK_WIDTH'(b)] <= r_pre_tmr[BANK_WIDTH'(b)] + 1'b1;
        if (w_pre_mask[BANK_WIDTH'(b)] && r_open[BANK_WIDTH'(b)]) begin
          r_open[BANK_WIDTH'(b)]    <= 1'b0;
          r_pre_tmr[BANK_WIDTH'(b)] <= TW'(1);
        end
      end
      if (w_do_act) begin
        r_open[bank_addr]    <= 1'b1;
        r_row[bank_addr]     <= addr[ROW_WIDTH-1:0];
        r_act_tmr[bank_addr] <= TW'(1);
      end
      if ((w_do_rd || w_do_wr) && addr[10]) begin
        r_open[bank_addr]    <= 1'b0;
        r_pre_tmr[bank_addr] <= TW'(1);
      end
      if (w_do_mrs) r_cl <= addr[6:4];

      // Each read lands in the stage matching its own CL, so later CL changes cannot move it.
      r_data_oe  <= r_pv[0];
      r_data_out <= r_pv[0] ? r_pd[0] : 8'h00;
      r_pv[0]    <= r_pv[1];
      r_pd[0]    <= r_pd[1];
      r_pv[1]    <= 1'b0;
      r_pd[1]    <= '0;
      if (w_do_rd) begin
        if (r_cl == 3'd3) begin
          r_pv[1] <= !data_mask;
          r_pd[1] <= w_rd_byte;
        end else begin
          r_pv[0] <= !data_mask;
          r_pd[0] <= w_rd_byte;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_wr && !data_mask) r_mem[w_idx] <= data_in;
  end

  assign data_out    = r_data_out;
  assign data_oe     = r_data_oe;
  assign init_done   = (r_state == S_READY);
  assign error       = r_error;
  assign error_code  = r_code;
  assign cas_latency = r_cl;

endmodule
